// File: rtl/id_stage.sv
// Instruction decode stage: 16x32 register file, ARM-style decoder, condition check and ID/EX register.
// Define ID_WB_BYPASS_EN to forward same-cycle write-back data onto register-file reads.
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [31:0] instruction,
  input  logic [3:0]  status,
  input  logic        hazard,
  input  logic        wb_en,
  input  logic [3:0]  wb_dest,
  input  logic [31:0] wb_value,
  output logic [3:0]  src1,
  output logic [3:0]  src2,
  output logic        two_src,
  output logic [31:0] pc_out,
  output logic [31:0] val_rn,
  output logic [31:0] val_rm,
  output logic [3:0]  exe_cmd,
  output logic        wb_en_out,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic        b_out,
  output logic        s_out,
  output logic        imm,
  output logic [11:0] shift_operand,
  output logic [23:0] signed_imm_24,
  output logic [3:0]  dest
);

  typedef enum logic [1:0] {
    MODE_DP  = 2'b00,
    MODE_MEM = 2'b01,
    MODE_BR  = 2'b10,
    MODE_NOP = 2'b11
  } mode_e;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_EOR = 4'b0001,
    OP_SUB = 4'b0010,
    OP_ADD = 4'b0100,
    OP_ADC = 4'b0101,
    OP_SBC = 4'b0110,
    OP_TST = 4'b1000,
    OP_CMP = 4'b1010,
    OP_ORR = 4'b1100,
    OP_MOV = 4'b1101,
    OP_MVN = 4'b1111
  } opcode_e;

  mode_e       mode;
  opcode_e     opcode;
  logic        is_str;
  logic [31:0] rf [16];
  logic [31:0] rd_rn, rd_rm;

  assign mode   = mode_e'(instruction[27:26]);
  assign opcode = opcode_e'(instruction[24:21]);
  assign is_str = (mode == MODE_MEM) && !instruction[20];

  assign src1    = instruction[19:16];
  assign src2    = is_str ? instruction[15:12] : instruction[3:0];
  assign two_src = !instruction[25] || is_str;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 16; i++) rf[i] <= '0;
    end else if (wb_en) begin
      rf[wb_dest] <= wb_value;
    end
  end

`ifdef ID_WB_BYPASS_EN
  assign rd_rn = (wb_en && wb_dest == src1) ? wb_value : rf[src1];
  assign rd_rm = (wb_en && wb_dest == src2) ? wb_value : rf[src2];
`else
  assign rd_rn = rf[src1];
  assign rd_rm = rf[src2];
`endif

  logic [3:0] dec_exe;
  logic       dec_wb, dec_mr, dec_mw, dec_b, dec_s;

  always_comb begin
    dec_exe = '0;
    dec_wb  = 1'b0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_b   = 1'b0;
    dec_s   = 1'b0;
    unique case (mode)
      MODE_DP: begin
        dec_wb = 1'b1;
        dec_s  = instruction[20];
        case (opcode)
          OP_MOV: dec_exe = 4'b0001;
          OP_MVN: dec_exe = 4'b1001;
          OP_ADD: dec_exe = 4'b0010;
          OP_ADC: dec_exe = 4'b0011;
          OP_SUB: dec_exe = 4'b0100;
          OP_SBC: dec_exe = 4'b0101;
          OP_AND: dec_exe = 4'b0110;
          OP_ORR: dec_exe = 4'b0111;
          OP_EOR: dec_exe = 4'b1000;
          OP_CMP: begin dec_exe = 4'b0100; dec_wb = 1'b0; dec_s = 1'b1; end
          OP_TST: begin dec_exe = 4'b0110; dec_wb = 1'b0; dec_s = 1'b1; end
          default: begin dec_wb = 1'b0; dec_s = 1'b0; end
        endcase
      end
      MODE_MEM: begin
        dec_exe = 4'b0010;
        dec_wb  = instruction[20];
        dec_mr  = instruction[20];
        dec_mw  = !instruction[20];
      end
      MODE_BR:  dec_b = 1'b1;
      MODE_NOP: ;
    endcase
  end

  logic n_f, z_f, c_f, v_f, cond_ok;
  assign {n_f, z_f, c_f, v_f} = status;

  always_comb begin
    cond_ok = 1'b0;
    case (instruction[31:28])
      4'b0000: cond_ok = z_f;
      4'b0001: cond_ok = !z_f;
      4'b0010: cond_ok = c_f;
      4'b0011: cond_ok = !c_f;
      4'b0100: cond_ok = n_f;
      4'b0101: cond_ok = !n_f;
      4'b0110: cond_ok = v_f;
      4'b0111: cond_ok = !v_f;
      4'b1000: cond_ok = c_f && !z_f;
      4'b1001: cond_ok = !c_f || z_f;
      4'b1010: cond_ok = (n_f == v_f);
      4'b1011: cond_ok = (n_f != v_f);
      4'b1100: cond_ok = !z_f && (n_f == v_f);
      4'b1101: cond_ok = z_f || (n_f != v_f);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // Killed instructions still carry their data fields so downstream forwarding sees stable values.
  logic kill;
  assign kill = hazard || !cond_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || flush) begin
      if (!rst || flush) begin
        pc_out        <= '0;
        val_rn        <= '0;
        val_rm        <= '0;
        exe_cmd       <= '0;
        wb_en_out     <= 1'b0;
        mem_r_en      <= 1'b0;
        mem_w_en      <= 1'b0;
        b_out         <= 1'b0;
        s_out         <= 1'b0;
        imm           <= 1'b0;
        shift_operand <= '0;
        signed_imm_24 <= '0;
        dest          <= '0;
      end
    end else if (!freeze) begin
      pc_out        <= pc_in;
      val_rn        <= rd_rn;
      val_rm        <= rd_rm;
      exe_cmd       <= kill ? 4'b0000 : dec_exe;
      wb_en_out     <= dec_wb && !kill;
      mem_r_en      <= dec_mr && !kill;
      mem_w_en      <= dec_mw && !kill;
      b_out         <= dec_b && !kill;
      s_out         <= dec_s && !kill;
      imm           <= instruction[25];
      shift_operand <= instruction[11:0];
      signed_imm_24 <= instruction[23:0];
      dest          <= instruction[15:12];
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: rule-level decode model compared every cycle plus directed literal checks.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, hazard, wb_en;
  logic [31:0] pc_in, instruction, wb_value;
  logic [3:0]  status, wb_dest;
  logic [3:0]  src1, src2;
  logic        two_src;
  logic [31:0] pc_out, val_rn, val_rm;
  logic [3:0]  exe_cmd, dest;
  logic        wb_en_out, mem_r_en, mem_w_en, b_out, s_out, imm;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .pc_in(pc_in),
    .instruction(instruction), .status(status), .hazard(hazard), .wb_en(wb_en),
    .wb_dest(wb_dest), .wb_value(wb_value), .src1(src1), .src2(src2), .two_src(two_src),
    .pc_out(pc_out), .val_rn(val_rn), .val_rm(val_rm), .exe_cmd(exe_cmd),
    .wb_en_out(wb_en_out), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .b_out(b_out),
    .s_out(s_out), .imm(imm), .shift_operand(shift_operand),
    .signed_imm_24(signed_imm_24), .dest(dest)
  );

  typedef struct packed {
    logic [31:0] pc, rn, rm;
    logic [3:0]  exe;
    logic        wb, mr, mw, b, s, im;
    logic [11:0] sh;
    logic [23:0] simm;
    logic [3:0]  dst;
  } ex_t;

  // ALU command per data-processing opcode (index = opcode); 0 marks an unsupported opcode.
  localparam logic [3:0] DP_EXE [16] = '{4'h6, 4'h8, 4'h4, 4'h0, 4'h2, 4'h3, 4'h5, 4'h0,
                                         4'h6, 4'h0, 4'h4, 4'h0, 4'h7, 4'h1, 4'h0, 4'h9};

  logic [31:0] m_rf [16];
  ex_t         m_ex;

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, t;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: t = z;
      3'd1: t = cy;
      3'd2: t = n;
      3'd3: t = v;
      3'd4: t = cy & ~z;
      3'd5: t = (n == v);
      3'd6: t = ~z & (n == v);
      default: t = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    if (c == 4'hE) return 1'b1;
    return c[0] ? ~t : t;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] idx);
`ifdef ID_WB_BYPASS_EN
    if (wb_en && wb_dest == idx) return wb_value;
`endif
    return m_rf[idx];
  endfunction

  function automatic logic m_is_str(input logic [31:0] ins);
    return ins[27:26] == 2'b01 && !ins[20];
  endfunction

  function automatic logic [3:0] m_src2(input logic [31:0] ins);
    return m_is_str(ins) ? ins[15:12] : ins[3:0];
  endfunction

  function automatic ex_t m_decode(input logic [31:0] ins);
    ex_t e;
    logic [3:0] op;
    op     = ins[24:21];
    e      = '0;
    e.pc   = pc_in;
    e.rn   = m_read(ins[19:16]);
    e.rm   = m_read(m_src2(ins));
    e.im   = ins[25];
    e.sh   = ins[11:0];
    e.simm = ins[23:0];
    e.dst  = ins[15:12];
    if (ins[27:26] == 2'b00) begin
      e.exe = DP_EXE[op];
      e.wb  = (e.exe != 0) && op != 4'b1000 && op != 4'b1010;
      e.s   = (op == 4'b1000 || op == 4'b1010) ? 1'b1 : (e.exe != 0 && ins[20]);
    end else if (ins[27:26] == 2'b01) begin
      e.exe = 4'b0010;
      e.mr  = ins[20];
      e.wb  = ins[20];
      e.mw  = !ins[20];
    end else if (ins[27:26] == 2'b10) begin
      e.b = 1'b1;
    end
    if (hazard || !cond_pass(ins[31:28], status)) begin
      e.exe = 0; e.wb = 0; e.mr = 0; e.mw = 0; e.b = 0; e.s = 0;
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) m_rf[i] <= '0;
      m_ex <= '0;
    end else begin
      if (flush)        m_ex <= '0;
      else if (!freeze) m_ex <= m_decode(instruction);
      if (wb_en) m_rf[wb_dest] <= wb_value;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    chk("m.pc_out", pc_out, m_ex.pc);
    chk("m.val_rn", val_rn, m_ex.rn);
    chk("m.val_rm", val_rm, m_ex.rm);
    chk("m.exe_cmd", 32'(exe_cmd), 32'(m_ex.exe));
    chk("m.ctrl", {wb_en_out, mem_r_en, mem_w_en, b_out, s_out, imm},
                  {m_ex.wb, m_ex.mr, m_ex.mw, m_ex.b, m_ex.s, m_ex.im});
    chk("m.fields", {shift_operand, dest}, {m_ex.sh, m_ex.dst});
    chk("m.simm", 32'(signed_imm_24), 32'(m_ex.simm));
    chk("m.src", {src1, src2, two_src},
                 {instruction[19:16], m_src2(instruction), !instruction[25] || m_is_str(instruction)});
  end

  task automatic cyc();
    @(posedge clk);
    #3;
    pc_in = pc_in + 32'd4;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [3:0] st);
    instruction = ins;
    status      = st;
    cyc();
  endtask

  logic [31:0] dp_vec [9] = '{32'hE1E01002, 32'hE0A11002, 32'hE0511002, 32'hE0C11002,
                              32'hE0011002, 32'hE1811002, 32'hE0211002, 32'hE1510002,
                              32'hE1110002};
  logic [31:0] held_pc;

  initial begin
    rst = 1'b0; freeze = 1'b0; flush = 1'b0; hazard = 1'b0;
    wb_en = 1'b0; wb_dest = '0; wb_value = '0;
    pc_in = 32'h100; instruction = '0; status = '0;
    #1;
    chk("reset.outputs", {pc_out, exe_cmd, wb_en_out, b_out}, '0);
    chk("reset.val_rn", val_rn, 32'h0);
    cyc(); cyc();
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      wb_en = 1'b1; wb_dest = 4'(i); wb_value = 32'h1000_0000 + 32'(i) * 32'h101;
      cyc();
    end
    wb_en = 1'b0;

    issue(32'hE3A00014, 4'b0000);
    chk("mov.exe_cmd", 32'(exe_cmd), 32'h1);
    chk("mov.wb_en_out", 32'(wb_en_out), 32'h1);
    chk("mov.imm_dest", {imm, dest}, {1'b1, 4'h0});
    chk("mov.shift_operand", 32'(shift_operand), 32'h014);

    issue(32'h10811001, 4'b0100);
    chk("addne_z1.ctrl", {exe_cmd, wb_en_out, mem_r_en, mem_w_en, b_out, s_out}, '0);
    issue(32'h10811001, 4'b0000);
    chk("addne_z0.exe_cmd", 32'(exe_cmd), 32'h2);
    chk("addne_z0.wb_en_out", 32'(wb_en_out), 32'h1);
    chk("addne_z0.val_rn", val_rn, 32'h1000_0101);

    instruction = 32'hE4001000;
    #1;
    chk("str.src2", 32'(src2), 32'h1);
    chk("str.two_src", 32'(two_src), 32'h1);
    cyc();
    chk("str.mem_w_en", {mem_w_en, wb_en_out}, {1'b1, 1'b0});

    wb_en = 1'b1; wb_dest = 4'd3; wb_value = 32'hCAFEF00D;
    issue(32'hE0830000, 4'b0000);
    wb_en = 1'b0;
`ifdef ID_WB_BYPASS_EN
    chk("bypass.val_rn", val_rn, 32'hCAFEF00D);
`else
    chk("bypass.val_rn", val_rn, 32'h1000_0303);
`endif
    issue(32'hE0830000, 4'b0000);
    chk("r3_after_write.val_rn", val_rn, 32'hCAFEF00D);

    issue(32'hE5912004, 4'b0000);
    chk("ldr.ctrl", {exe_cmd, wb_en_out, mem_r_en, mem_w_en}, {4'h2, 1'b1, 1'b1, 1'b0});
    foreach (dp_vec[k]) issue(dp_vec[k], 4'b0000);
    chk("tst.ctrl", {exe_cmd, wb_en_out, s_out}, {4'h6, 1'b0, 1'b1});

    for (int c = 0; c < 16; c++) begin
      issue({4'(c), 28'h0811001}, 4'(c * 5));
      issue({4'(c), 28'h0811001}, 4'(~(c * 3)));
    end

    hazard = 1'b1;
    issue(32'hE3A00014, 4'b0000);
    hazard = 1'b0;
    chk("hazard.ctrl", {exe_cmd, wb_en_out}, '0);
    chk("hazard.data", {imm, shift_operand}, {1'b1, 12'h014});

    issue(32'hEC000000, 4'b0000);
    chk("mode11.ctrl", {exe_cmd, wb_en_out, mem_r_en, mem_w_en, b_out, s_out}, '0);

    issue(32'hBAFFFFF7, 4'b1000);
    held_pc = pc_in - 32'd4;
    chk("blt.b_out", 32'(b_out), 32'h1);
    freeze = 1'b1;
    instruction = 32'hE3A00014;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("freeze.hold", {b_out, signed_imm_24, exe_cmd}, {1'b1, 24'hFFFFF7, 4'h0});
      chk("freeze.pc", pc_out, held_pc);
    end
    instruction = 32'hBAFFFFF7;
    flush = 1'b1;
    cyc();
    flush = 1'b0; freeze = 1'b0;
    chk("flush_freeze.clear", {b_out, signed_imm_24, pc_out}, '0);

    issue(32'hE3A00014, 4'b0000);
    rst = 1'b0;
    #1;
    chk("midreset.outputs", {exe_cmd, wb_en_out, imm, shift_operand}, '0);
    chk("midreset.pc_out", pc_out, 32'h0);
    instruction = 32'hE0830000;
    cyc();
    rst = 1'b1;
    cyc();
    chk("post_reset.exe_cmd", 32'(exe_cmd), 32'h2);
    chk("post_reset.r3", val_rn, 32'h0);
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
